// File: rtl/squash_sequencer.sv
// Registered squash scheduler: picks the oldest valid squash, holds it until the front end takes it.
// Optional younger-squash suppression filter is enabled with `SQUASH_SEQUENCER_FILTER_EN.
module squash_sequencer #(
    parameter int p_num_src      = 2,
    parameter int p_seq_num_bits = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [p_num_src*p_seq_num_bits-1:0] src_seq_num,
    input  logic [p_num_src*32-1:0]             src_target,
    input  logic [p_num_src-1:0]                src_val,
    input  logic [p_seq_num_bits-1:0]           commit_seq_num,
    input  logic                                commit_val,
    output logic [p_seq_num_bits-1:0]           gnt_seq_num,
    output logic [31:0]                         gnt_target,
    output logic                                gnt_val,
    input  logic                                gnt_rdy,
    output logic                                busy
);

    // Handshake: gnt_val/gnt_* are presented while PENDING; a transfer happens on
    // any cycle with gnt_val & gnt_rdy. The payload may be replaced by an older
    // squash while gnt_rdy is low, so it is not guaranteed stable.

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic [0:0]                state_q, state_d;
    logic [p_seq_num_bits-1:0] tail_q, tail_d;
    logic [p_seq_num_bits-1:0] hold_seq_q, hold_seq_d;
    logic [31:0]               hold_tgt_q, hold_tgt_d;

    logic [p_seq_num_bits-1:0] cand_seq;
    logic [31:0]               cand_tgt;
    logic                      cand_val;
    logic                      accept;
    logic                      take;
    logic                      fire;

    // Ages are distances from the oldest uncommitted sequence number.
    function automatic logic older(input logic [p_seq_num_bits-1:0] a,
                                   input logic [p_seq_num_bits-1:0] b,
                                   input logic [p_seq_num_bits-1:0] t);
        logic [p_seq_num_bits-1:0] da;
        logic [p_seq_num_bits-1:0] db;
        da = a - t;
        db = b - t;
        return da < db;
    endfunction

    // Strictly-older replacement keeps the lower index on equal sequence numbers.
    always_comb begin
        cand_val = 1'b0;
        cand_seq = '0;
        cand_tgt = '0;
        for (int i = 0; i < p_num_src; i++) begin
            if (src_val[i] &&
                (!cand_val || older(src_seq_num[i*p_seq_num_bits +: p_seq_num_bits], cand_seq, tail_q))) begin
                cand_val = 1'b1;
                cand_seq = src_seq_num[i*p_seq_num_bits +: p_seq_num_bits];
                cand_tgt = src_target[i*32 +: 32];
            end
        end
    end

    assign fire = (state_q == ST_PENDING) && gnt_rdy;

`ifdef SQUASH_SEQUENCER_FILTER_EN
    logic [p_seq_num_bits-1:0] flt_seq_q, flt_seq_d;
    logic                      flt_val_q, flt_val_d;

    assign accept = cand_val && (!flt_val_q || older(cand_seq, flt_seq_q, tail_q));

    // A fire re-arms the filter even when the clearing commit lands in the same cycle.
    always_comb begin
        flt_seq_d = flt_seq_q;
        flt_val_d = flt_val_q;
        if (fire) begin
            flt_seq_d = hold_seq_q;
            flt_val_d = 1'b1;
        end else if (commit_val && (commit_seq_num == flt_seq_q)) begin
            flt_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flt_seq_q <= '0;
            flt_val_q <= 1'b0;
        end else begin
            flt_seq_q <= flt_seq_d;
            flt_val_q <= flt_val_d;
        end
    end

    assign busy = (state_q == ST_PENDING) || flt_val_q;
`else
    assign accept = cand_val;
    assign busy   = (state_q == ST_PENDING);
`endif

    assign take = accept && older(cand_seq, hold_seq_q, tail_q);

    always_comb begin
        state_d    = state_q;
        hold_seq_d = hold_seq_q;
        hold_tgt_d = hold_tgt_q;
        tail_d     = tail_q;
        if (commit_val) begin
            tail_d = commit_seq_num + p_seq_num_bits'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    hold_seq_d = cand_seq;
                    hold_tgt_d = cand_tgt;
                    state_d    = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (take) begin
                    hold_seq_d = cand_seq;
                    hold_tgt_d = cand_tgt;
                end else if (fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tail_q     <= '0;
            hold_seq_q <= '0;
            hold_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            tail_q     <= tail_d;
            hold_seq_q <= hold_seq_d;
            hold_tgt_q <= hold_tgt_d;
        end
    end

    assign gnt_val     = (state_q == ST_PENDING);
    assign gnt_seq_num = hold_seq_q;
    assign gnt_target  = hold_tgt_q;

endmodule

// File: doc/squash_sequencer.md
# squash_sequencer

Registered squash scheduler between the squash sources (execute units, memory ordering, exceptions) and the front-end redirect path. Each cycle it selects the oldest valid squash across `p_num_src` sources and holds it until the front end accepts it with a valid/ready handshake. While holding, it replaces the held squash with any strictly older one. After firing, it suppresses younger squashes until the squashing instruction commits. It keeps its own age reference from the commit stream.

## Interface
- `p_num_src`, 2: number of squash sources (≥1).
- `p_seq_num_bits`, 5: sequence-number width; ages compare modulo 2^`p_seq_num_bits`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high.
- `src_seq_num`  in  `p_num_src*p_seq_num_bits`  source i at `[i*p_seq_num_bits +: p_seq_num_bits]`.
- `src_target`  in  `p_num_src*32`  redirect PC; source i at `[i*32 +: 32]`.
- `src_val`  in  `p_num_src`  per-source squash valid.
- `commit_seq_num`  in  `p_seq_num_bits`  sequence number of the committing instruction.
- `commit_val`  in  1  commit valid.
- `gnt_seq_num`  out  `p_seq_num_bits`  held squash sequence number.
- `gnt_target`  out  32  held redirect PC.
- `gnt_val`  out  1  squash presented.
- `gnt_rdy`  in  1  front end accepts; fire = `gnt_val & gnt_rdy`.
- `busy`  out  1  high when in PENDING, or when the filter is armed.

## Operation
- **Age reference.** Register `tail` resets to 0. On `commit_val`, `tail <= commit_seq_num + 1` (wraps). `older(a,b) = (a - tail) < (b - tail)`, unsigned, `p_seq_num_bits` wide.
- **Candidate.** The oldest source with `src_val` set. On equal sequence numbers, the lower index wins. No candidate exists if no `src_val` bit is set.
- **Filter.** Registers `flt_seq`, `flt_val`, reset to 0.
  - A candidate is dropped if `flt_val` is set and `!older(cand, flt_seq)`.
  - On fire: `flt_seq <= gnt_seq_num`, `flt_val <= 1`.
  - `flt_val` clears on `commit_val && commit_seq_num == flt_seq`.
  - A fire in the same cycle as that clearing commit re-arms the filter; fire wins.
- **State machine**, reset IDLE:
  - IDLE: an accepted candidate loads the hold register; next state PENDING.
  - PENDING, no fire: if the candidate is older than the held squash, replace the held squash. Stay PENDING.
  - PENDING, fire: if the candidate is older than the fired `gnt_seq_num` (and passes the filter), load it and stay PENDING. Otherwise go to IDLE.
- **Outputs.**
  - `gnt_val = (state == PENDING)`.
  - `gnt_seq_num` and `gnt_target` come straight from the hold register. They may change while `gnt_val` is high and `gnt_rdy` is low (an older squash takes precedence). Consumers must not assume the payload is stable.
- **Reset values.** `gnt_val = 0`, `gnt_seq_num = 0`, `gnt_target = 0`, `busy = 0`, `tail = 0`, filter cleared.
- **Reset mid-operation.** Reset asserted while PENDING drops `gnt_val` immediately (asynchronous). The held squash is discarded and not replayed.

## Timing
- Latency is 1 cycle: `src_val` at edge N gives `gnt_val` and payload after edge N+1.
- No combinational path from `src_*` to `gnt_*`. The only combinational path from `gnt_rdy` is into next-state logic.
- Back-to-back throughput: one squash per cycle when successive squashes are each strictly older than the previous one.
- A commit in cycle N affects age comparisons from cycle N+1. Same-cycle comparisons use the old `tail`.
- A replacement in cycle N is visible on `gnt_*` in cycle N+1. A fire in cycle N refers to the cycle-N payload.

## Configuration
- Macro: `SQUASH_SEQUENCER_FILTER_EN`.
- **Defined:** `flt_seq`/`flt_val` and suppression are implemented as above.
- **Undefined:** the filter logic is removed.
  - Candidates are compared only against the held squash.
  - After a fire, any candidate is accepted. The front end must tolerate redundant younger redirects.
  - `busy` equals `gnt_val`.

## Test plan
All scenarios use `p_num_src=2`, `p_seq_num_bits=5`, filter enabled.
- **Reset:** assert `rst` mid-PENDING with `gnt_seq_num=6` → `gnt_val=0` and `busy=0` without a clock edge. After deassert, `gnt_val` stays 0 with no sources valid.
- **Single squash:** src0 seq 3, target 0x100, one cycle, `gnt_rdy=1` → next cycle `gnt_val=1`, seq 3, target 0x100. The cycle after, `gnt_val=0`.
- **Simultaneous sources:** `tail=0`, src0 seq 7, src1 seq 4 → grant seq 4 with src1's target. Equal seq 4 on both sources → src0 target granted.
- **Wrap:** commit seq 29 (`tail=30`), then src0 seq 1, src1 seq 31 → grant seq 31.
- **Hold and replace:** `gnt_rdy=0`, held seq 6; src seq 2 arrives → payload becomes seq 2 next cycle and `gnt_val` stays 1; a later src seq 9 is ignored.
- **Filter:** fire seq 5 → src seq 8 next cycle is dropped; src seq 3 is granted. After commit seq 5 and fire of 3, commit seq 3 clears the filter; then src seq 8 is granted.
